// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM states, program entry points
// and the absolute branch-target table.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned PKG_PC_W = 10;
  typedef logic [PKG_PC_W-1:0] pkg_pc_t;

  localparam pkg_pc_t PROG_BASE [4] = '{
    10'h040, 10'h100, 10'h200, 10'h000
  };

  localparam pkg_pc_t BRANCH_LUT [32] = '{
    10'h3FC, 10'h020, 10'h040, 10'h060, 10'h080, 10'h0A0, 10'h0C0, 10'h0E0,
    10'h100, 10'h120, 10'h140, 10'h160, 10'h180, 10'h1A0, 10'h1C0, 10'h1E0,
    10'h200, 10'h220, 10'h240, 10'h260, 10'h280, 10'h2A0, 10'h2C0, 10'h2E0,
    10'h300, 10'h320, 10'h340, 10'h360, 10'h380, 10'h3A0, 10'h3C0, 10'h3FF
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: maps an instruction's target index to
// an absolute PC.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 5
) (
  input  logic [LUT_IDX_W-1:0] TargetIdx,
  output logic [PC_W-1:0]      Target
);

  always_comb begin
    Target = PC_W'(BRANCH_LUT[TargetIdx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: starts a selected program, steps or branches
// the PC each RUN cycle, and counts RUN cycles until a halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           ProgSel,
  input  logic                 Halt,
  input  logic                 Jump,
  input  logic                 BranchEn,
  input  logic                 BranchAccept,
  input  logic [LUT_IDX_W-1:0] TargetIdx,
  output logic [PC_W-1:0]      PC,
  output logic                 Running,
  output logic                 Done,
  output logic [15:0]          CycleCount
);

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [15:0]       r_cnt;
  logic [15:0]       w_cnt_next;
  logic [PC_W-1:0]   w_target;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .TargetIdx (TargetIdx),
    .Target    (w_target)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE, DONE: begin
        if (Start) begin
          w_state_next = RUN;
          w_pc_next    = PC_W'(PROG_BASE[ProgSel]);
          w_cnt_next   = '0;
        end
      end
      RUN: begin
        // The halting cycle still counts as a RUN cycle.
        if (r_cnt != '1) w_cnt_next = r_cnt + 16'd1;
        if (Halt) begin
          w_state_next = DONE;
        end else if (Jump || (BranchEn && BranchAccept)) begin
          w_pc_next = w_target;
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign PC         = r_pc;
  assign CycleCount = r_cnt;
  assign Running    = (r_state == RUN);
  assign Done       = (r_state == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit with a behavioural model and
// directed literal checks on the documented scenarios.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [1:0] ProgSel;
  logic       Halt;
  logic       Jump;
  logic       BranchEn;
  logic       BranchAccept;
  logic [4:0] TargetIdx;
  logic [9:0] PC;
  logic       Running;
  logic       Done;
  logic [15:0] CycleCount;

  int n_cmp = 0;
  int n_err = 0;

  // Independent copies of the program bases and branch targets.
  int base_tab [4]  = '{64, 256, 512, 0};
  int lut_tab  [32] = '{1020, 32, 64, 96, 128, 160, 192, 224,
                        256, 288, 320, 352, 384, 416, 448, 480,
                        512, 544, 576, 608, 640, 672, 704, 736,
                        768, 800, 832, 864, 896, 928, 960, 1023};

  bit m_valid = 0;
  bit m_run   = 0;
  bit m_done  = 0;
  int m_pc    = 0;
  int m_cnt   = 0;

  fetch_unit #(
    .PC_W      (10),
    .LUT_IDX_W (5)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .ProgSel      (ProgSel),
    .Halt         (Halt),
    .Jump         (Jump),
    .BranchEn     (BranchEn),
    .BranchAccept (BranchAccept),
    .TargetIdx    (TargetIdx),
    .PC           (PC),
    .Running      (Running),
    .Done         (Done),
    .CycleCount   (CycleCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on each edge from the inputs held across it, then the
  // registered outputs are checked just after the edge.
  always @(posedge Clk) begin
    if (Reset) begin
      m_valid = 1; m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (m_run) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (Halt) begin
        m_run = 0; m_done = 1;
      end else if (Jump || (BranchEn && BranchAccept)) begin
        m_pc = lut_tab[TargetIdx];
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end else if (Start) begin
      m_run = 1; m_done = 0; m_pc = base_tab[ProgSel]; m_cnt = 0;
    end
    #1;
    if (m_valid) begin
      chk("model_pc", 32'(PC), 32'(m_pc));
      chk("model_cnt", 32'(CycleCount), 32'(m_cnt));
      chk("model_running", 32'(Running), 32'(m_run));
      chk("model_done", 32'(Done), 32'(m_done));
    end
  end

  task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                      input logic h, input logic j, input logic be,
                      input logic ba, input logic [4:0] idx);
    Reset = rst; Start = st; ProgSel = sel; Halt = h; Jump = j;
    BranchEn = be; BranchAccept = ba; TargetIdx = idx;
    @(posedge Clk);
    #2;
  endtask

  task automatic step_rand(input bit allow_halt, input bit allow_reset);
    step(allow_reset && ($urandom_range(0, 63) == 0),
         $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
         allow_halt && ($urandom_range(0, 15) == 0),
         $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  initial begin
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(PC), 0);
    chk("reset_running", 32'(Running), 0);
    chk("reset_done", 32'(Done), 0);

    step(0, 0, 0, 1, 1, 1, 1, 7);
    chk("idle_ignores_ctrl_pc", 32'(PC), 0);
    chk("idle_ignores_ctrl_run", 32'(Running), 0);

    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("start_pc", 32'(PC), 256);
    chk("start_running", 32'(Running), 1);
    chk("start_cnt", 32'(CycleCount), 0);

    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 9);
    chk("seq_pc", 32'(PC), 261);
    chk("seq_cnt", 32'(CycleCount), 5);

    step(0, 0, 0, 0, 0, 1, 1, 3);
    chk("branch_taken_pc", 32'(PC), 96);
    step(0, 0, 0, 0, 0, 1, 0, 3);
    chk("branch_not_taken_pc", 32'(PC), 97);

    step(0, 0, 0, 1, 1, 0, 0, 5);
    chk("halt_pc", 32'(PC), 97);
    chk("halt_done", 32'(Done), 1);
    chk("halt_running", 32'(Running), 0);
    chk("halt_cnt", 32'(CycleCount), 8);

    step(0, 0, 0, 0, 1, 0, 0, 5);
    chk("done_hold_pc", 32'(PC), 97);
    chk("done_hold_cnt", 32'(CycleCount), 8);

    step(0, 1, 2, 0, 0, 0, 0, 0);
    chk("restart_pc", 32'(PC), 512);
    chk("restart_running", 32'(Running), 1);
    chk("restart_cnt", 32'(CycleCount), 0);

    step(0, 0, 0, 0, 1, 0, 0, 31);
    chk("jump_pc", 32'(PC), 1023);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", 32'(PC), 0);

    step(1, 1, 1, 0, 0, 0, 0, 0);
    chk("abort_pc", 32'(PC), 0);
    chk("abort_done", 32'(Done), 0);
    chk("abort_running", 32'(Running), 0);
    chk("abort_cnt", 32'(CycleCount), 0);

    step(0, 1, 3, 0, 0, 0, 0, 0);
    chk("start3_pc", 32'(PC), 0);
    for (int unsigned i = 0; i < 65540; i++) step_rand(0, 0);
    chk("saturate_cnt", 32'(CycleCount), 65535);
    chk("saturate_running", 32'(Running), 1);

    for (int unsigned i = 0; i < 3000; i++) step_rand(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
